mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Three-port memory arbiter: host (strict priority), datapath and
// instruction fetch (round-robin between them) share one memory port.
module mem_port_arbiter #(
    parameter int unsigned DATA_W  = 28,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              h_ack,
    output logic              d_ack,
    output logic              f_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        gnt_id
);

    localparam int unsigned CNT_W     = 2;
    localparam int unsigned WAIT_LOAD = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;

    localparam logic [1:0] ID_NONE  = 2'd0;
    localparam logic [1:0] ID_HOST  = 2'd1;
    localparam logic [1:0] ID_DATA  = 2'd2;
    localparam logic [1:0] ID_FETCH = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_dataside;
    logic               last_dataside_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_nxt;
    logic               acc_we;

    logic [1:0]         win_id;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;

    // Next-state logic and winner selection; a grant can only happen in IDLE.
    always_comb begin
        state_nxt         = state;
        last_dataside_nxt = last_dataside;
        wait_cnt_nxt      = wait_cnt;
        win_id            = ID_NONE;
        win_we            = 1'b0;
        win_addr          = mem_addr;
        win_wdata         = mem_wdata;
        case (state)
            IDLE: begin
                if (h_req) begin
                    win_id    = ID_HOST;
                    win_we    = h_we;
                    win_addr  = h_addr;
                    win_wdata = h_wdata;
                end else if (d_req && (!f_req || !last_dataside)) begin
                    win_id            = ID_DATA;
                    win_we            = d_we;
                    win_addr          = d_addr;
                    win_wdata         = d_wdata;
                    last_dataside_nxt = 1'b1;
                end else if (f_req) begin
                    win_id            = ID_FETCH;
                    win_addr          = f_addr;
                    last_dataside_nxt = 1'b0;
                end
                if (win_id != ID_NONE) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (MEM_LAT <= 1) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = CNT_W'(WAIT_LOAD);
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, round-robin pointer and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_dataside <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            state         <= state_nxt;
            last_dataside <= last_dataside_nxt;
            wait_cnt      <= wait_cnt_nxt;
        end
    end

    // Registered outputs; address/data latched at the grant and held afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_we    <= 1'b0;
            gnt_id    <= ID_NONE;
            h_ack     <= 1'b0;
            d_ack     <= 1'b0;
            f_ack     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            busy   <= (state_nxt != IDLE);
            mem_en <= (win_id != ID_NONE);
            mem_we <= (win_id != ID_NONE) && win_we;
            h_ack  <= (state_nxt == RESP) && (gnt_id == ID_HOST);
            d_ack  <= (state_nxt == RESP) && (gnt_id == ID_DATA);
            f_ack  <= (state_nxt == RESP) && (gnt_id == ID_FETCH);
            if (win_id != ID_NONE) begin
                gnt_id    <= win_id;
                acc_we    <= win_we;
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
            end else if (state_nxt == IDLE) begin
                gnt_id <= ID_NONE;
            end
            if ((state_nxt == RESP) && !acc_we) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule
